data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port data memory arbiter with IDLE/ACCESS/RESP transaction FSM.
// Optional round-robin tie-break enabled by macro DMARB_ROUND_ROBIN_EN (fixed A-priority otherwise).
module data_mem_arbiter #(
    parameter int Bits    = 64,
    parameter int MemSize = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [Bits-1:0] a_addr,
    input  logic [Bits-1:0] a_wdata,
    output logic            a_ack,
    output logic            a_err,
    output logic [Bits-1:0] a_rdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [Bits-1:0] b_addr,
    input  logic [Bits-1:0] b_wdata,
    output logic            b_ack,
    output logic            b_err,
    output logic [Bits-1:0] b_rdata,
    output logic [Bits-1:0] mem_access_addr,
    output logic [Bits-1:0] mem_write_data,
    output logic            mem_write_en,
    output logic            mem_read,
    input  logic [Bits-1:0] mem_read_data,
    output logic            busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [Bits-1:0] MemLimit = Bits'(MemSize);

    state_e          state_q, state_d;
    logic            win_b_q, win_b_d;
    logic            we_q, we_d;
    logic [Bits-1:0] addr_q, addr_d;
    logic [Bits-1:0] wdata_q, wdata_d;
    logic [Bits-1:0] rdata_a_q, rdata_b_q;
    logic            any_req;
    logic            grant_b;
    logic            in_range;
    logic [Bits-1:0] rd_value;

    assign any_req  = a_req | b_req;
    assign in_range = (addr_q < MemLimit);
    // Writes and out-of-range accesses report zero rather than whatever the memory drives.
    assign rd_value = (!we_q && in_range) ? mem_read_data : '0;

`ifdef DMARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    assign grant_b = b_req & (~a_req | ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && any_req) begin
            ptr_d = ~grant_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign grant_b = b_req & ~a_req;
`endif

    always_comb begin
        state_d = state_q;
        win_b_d = win_b_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    win_b_d = grant_b;
                    we_d    = grant_b ? b_we    : a_we;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q <= state_d;
            win_b_q <= win_b_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (state_q == ACCESS) begin
                if (win_b_q) begin
                    rdata_b_q <= rd_value;
                end else begin
                    rdata_a_q <= rd_value;
                end
            end
        end
    end

    // Memory strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (state_q == ACCESS) begin
            mem_access_addr = addr_q;
            mem_write_data  = wdata_q;
            mem_write_en    = we_q & in_range;
            mem_read        = ~we_q & in_range;
        end
    end

    assign busy    = (state_q != IDLE);
    assign a_ack   = (state_q == RESP) & ~win_b_q;
    assign b_ack   = (state_q == RESP) & win_b_q;
    assign a_err   = a_ack & ~in_range;
    assign b_err   = b_ack & ~in_range;
    assign a_rdata = rdata_a_q;
    assign b_rdata = rdata_b_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter against a memory/port model.
module tb_data_mem_arbiter;
`ifdef DMARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [63:0] a_rdata, b_rdata;
    logic [63:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read, busy;

    logic [63:0] bmem [16];
    logic [63:0] model_mem [16];
    logic [63:0] exp_a_rd, exp_b_rd;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.Bits(64), .MemSize(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    // Environment memory: combinational read of the low index bits, write on posedge.
    assign mem_read_data = bmem[mem_access_addr[3:0]];
    always @(posedge clk) begin
        if (mem_write_en && mem_access_addr < 64'd16) bmem[mem_access_addr[3:0]] <= mem_write_data;
    end

    task automatic drive(input bit pb, input bit req, input bit we, input logic [63:0] addr, input logic [63:0] wd);
        if (pb) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd; a_req = 1'b0;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd; b_req = 1'b0;
        end
    endtask

    task automatic txn(input bit pb, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] late_addr);
        bit inr;
        logic [63:0] exp_rd;
        inr    = (addr < 64'd16);
        exp_rd = (!we && inr) ? model_mem[addr[3:0]] : 64'd0;
        @(negedge clk);
        drive(pb, 1'b1, we, addr, wd);
        @(negedge clk);
        drive(pb, 1'b0, ~we, late_addr, ~wd);
        #1;
        checks++;
        if ({busy, mem_write_en, mem_read, a_ack, b_ack} !== {1'b1, we && inr, !we && inr, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL access_strobes busy/we/rd/aack/back got=%b want=%b",
                     {busy, mem_write_en, mem_read, a_ack, b_ack}, {1'b1, we && inr, !we && inr, 1'b0, 1'b0});
        end
        checks++;
        if (mem_access_addr !== addr || mem_write_data !== wd) begin
            failures++;
            $display("FAIL access_bus addr=%h data=%h want addr=%h data=%h", mem_access_addr, mem_write_data, addr, wd);
        end
        @(negedge clk);
        if (we && inr) model_mem[addr[3:0]] = wd;
        if (pb) exp_b_rd = exp_rd; else exp_a_rd = exp_rd;
        checks++;
        if ({a_ack, b_ack, a_err, b_err} !== {!pb, pb, !pb && !inr, pb && !inr}) begin
            failures++;
            $display("FAIL resp_ack aack/back/aerr/berr got=%b want=%b",
                     {a_ack, b_ack, a_err, b_err}, {!pb, pb, !pb && !inr, pb && !inr});
        end
        checks++;
        if (a_rdata !== exp_a_rd || b_rdata !== exp_b_rd) begin
            failures++;
            $display("FAIL resp_rdata a=%h b=%h want a=%h b=%h", a_rdata, b_rdata, exp_a_rd, exp_b_rd);
        end
        @(negedge clk);
        checks++;
        if ({busy, a_ack, b_ack, mem_write_en, mem_read} !== 5'b0 || mem_access_addr !== 64'd0 ||
            a_rdata !== exp_a_rd || b_rdata !== exp_b_rd) begin
            failures++;
            $display("FAIL idle_after_resp flags=%b addr=%h a=%h b=%h want flags=0 addr=0 a=%h b=%h",
                     {busy, a_ack, b_ack, mem_write_en, mem_read}, mem_access_addr, a_rdata, b_rdata, exp_a_rd, exp_b_rd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 64'd1; a_wdata = 64'hdead;
        b_req = 1'b1; b_we = 1'b0; b_addr = 64'd2; b_wdata = 64'hbeef;
        exp_a_rd = 64'd0; exp_b_rd = 64'd0;
        #1;
        repeat (3) begin
            checks++;
            if ({busy, a_ack, b_ack, a_err, b_err, mem_write_en, mem_read} !== 7'b0 ||
                mem_access_addr !== 64'd0 || mem_write_data !== 64'd0 || a_rdata !== 64'd0 || b_rdata !== 64'd0) begin
                failures++;
                $display("FAIL reset_outputs flags=%b addr=%h wd=%h a=%h b=%h want all zero",
                         {busy, a_ack, b_ack, a_err, b_err, mem_write_en, mem_read},
                         mem_access_addr, mem_write_data, a_rdata, b_rdata);
            end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        txn(1'b0, 1'b1, 64'd3, 64'h1234, 64'd9);
        txn(1'b0, 1'b0, 64'd3, 64'd0, 64'd9);
        checks++;
        if (a_rdata !== 64'h1234) begin
            failures++;
            $display("FAIL write_read_a3 got=%h want=%h", a_rdata, 64'h1234);
        end
        txn(1'b1, 1'b0, 64'd16, 64'd0, 64'd1);
        txn(1'b0, 1'b0, 64'd2, 64'd0, 64'd7);
        txn(1'b1, 1'b1, 64'h8000_0000_0000_0005, 64'h55, 64'd5);
    endtask

    task automatic test_random();
        logic [63:0] addr;
        for (int i = 0; i < 24; i++) begin
            addr = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} | 64'h10 : 64'($urandom_range(0, 19));
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, {$urandom, $urandom},
                64'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 64'd3; b_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if ({a_ack, b_ack, busy} !== {c == 2 || c == 5, 1'b0, !(c == 3 || c == 6 || c == 7)}) begin
                failures++;
                $display("FAIL back_to_back cycle=%0d aack/back/busy got=%b want=%b", c,
                         {a_ack, b_ack, busy}, {c == 2 || c == 5, 1'b0, !(c == 3 || c == 6 || c == 7)});
            end
            if (c == 2 || c == 5) begin
                exp_a_rd = model_mem[3];
                checks++;
                if (a_rdata !== exp_a_rd) begin
                    failures++;
                    $display("FAIL back_to_back_rdata cycle=%0d got=%h want=%h", c, a_rdata, exp_a_rd);
                end
            end
            if (c == 5) a_req = 1'b0;
        end
    endtask

    task automatic test_reset_during_access();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 64'd5, ~model_mem[5]);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        checks++;
        if (mem_write_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_access_we_before got=%b want=1", mem_write_en);
        end
        #1 rst_n = 1'b0;
        #1;
        exp_a_rd = 64'd0; exp_b_rd = 64'd0;
        checks++;
        if ({busy, a_ack, b_ack, a_err, b_err, mem_write_en, mem_read} !== 7'b0 ||
            mem_access_addr !== 64'd0 || mem_write_data !== 64'd0 || a_rdata !== 64'd0 || b_rdata !== 64'd0) begin
            failures++;
            $display("FAIL rst_access_async flags=%b addr=%h wd=%h a=%h b=%h want all zero",
                     {busy, a_ack, b_ack, a_err, b_err, mem_write_en, mem_read},
                     mem_access_addr, mem_write_data, a_rdata, b_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, a_ack, b_ack} !== 3'b0) begin
                failures++;
                $display("FAIL rst_access_no_ack cycle=%0d busy/aack/back got=%b want=000", c, {busy, a_ack, b_ack});
            end
        end
        checks++;
        if (bmem[5] !== model_mem[5]) begin
            failures++;
            $display("FAIL rst_access_mem5 got=%h want=%h", bmem[5], model_mem[5]);
        end
    endtask

    task automatic test_contention();
        bit exp_b, exp_ack;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 64'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 64'd2;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            exp_ack = (c % 3 == 2);
            exp_b   = (c == 14) ? 1'b1 : (RR && ((c - 2) / 3) % 2 == 1);
            checks++;
            if ({a_ack, b_ack, busy} !== {exp_ack && !exp_b, exp_ack && exp_b, c % 3 != 0}) begin
                failures++;
                $display("FAIL contention cycle=%0d aack/back/busy got=%b want=%b", c,
                         {a_ack, b_ack, busy}, {exp_ack && !exp_b, exp_ack && exp_b, c % 3 != 0});
            end
            if (c == 11) a_req = 1'b0;
            if (c == 14) b_req = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            bmem[i]      = {$urandom, $urandom};
            model_mem[i] = bmem[i];
        end
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_during_access();
        test_contention();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bmem[i] !== model_mem[i]) begin
                failures++;
                $display("FAIL final_mem idx=%0d got=%h want=%h", i, bmem[i], model_mem[i]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
